// File: rtl/lfsr_stream_checker.sv
// Receive-side PRBS checker: self-synchronises a local copy of an 8-bit Fibonacci
// LFSR to the incoming serial stream, confirms lock, then counts bit errors.
module lfsr_stream_checker #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned LOCK_COUNT  = 16,
   parameter int unsigned WIN_LEN     = 32,
   parameter int unsigned LOSS_THRESH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       tap,
   input  logic             rx_valid,
   input  logic             rx_bit,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [7:0] LockCnt = 8'(LOCK_COUNT);
   localparam logic [7:0] WinLast = 8'(WIN_LEN - 1);
   localparam logic [7:0] LossThr = 8'(LOSS_THRESH);

   typedef enum logic [1:0] {StSeed, StVerify, StLocked} state_e;

   state_e           state_q, state_d;
   logic [7:0]       shadow_q, shadow_d;
   logic [2:0]       fill_q, fill_d;
   logic [7:0]       match_q, match_d;
   logic [7:0]       win_q, win_d;
   logic [7:0]       werr_q, werr_d;
   logic [7:0]       tap_q, tap_d;
   logic             tap_init_q;
   logic             locked_q, locked_d;
   logic             err_pulse_q, err_pulse_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;

   logic predicted;
   logic mismatch;
   logic load_tap;

   assign predicted = ^(shadow_q & tap_q);
   assign mismatch  = rx_bit ^ predicted;

   // Next-state logic: clear overrides everything; otherwise advance only on rx_valid.
   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      fill_d      = fill_q;
      match_d     = match_q;
      win_d       = win_q;
      werr_d      = werr_q;
      err_count_d = err_count_q;
      err_pulse_d = 1'b0;
      load_tap    = 1'b0;

      if (clear) begin
         state_d     = StSeed;
         fill_d      = 3'd0;
         err_count_d = '0;
         load_tap    = 1'b1;
      end else if (rx_valid) begin
         unique case (state_q)
            StSeed: begin
               shadow_d = {shadow_q[6:0], rx_bit};
               fill_d   = fill_q + 3'd1;
               if (fill_q == 3'd7) begin
                  state_d = StVerify;
                  match_d = 8'd0;
               end
            end
            StVerify: begin
               shadow_d = {shadow_q[6:0], rx_bit};
               if (!mismatch) begin
                  match_d = match_q + 8'd1;
                  if (match_d == LockCnt) begin
                     state_d = StLocked;
                     win_d   = 8'd0;
                     werr_d  = 8'd0;
                  end
               end else begin
                  state_d  = StSeed;
                  fill_d   = 3'd0;
                  load_tap = 1'b1;
               end
            end
            StLocked: begin
               // Shift the prediction, not the received bit, so errors do not multiply.
               shadow_d = {shadow_q[6:0], predicted};
               win_d    = win_q + 8'd1;
               werr_d   = werr_q + {7'd0, mismatch};
               if (mismatch) begin
                  err_pulse_d = 1'b1;
                  if (err_count_q != '1) begin
                     err_count_d = err_count_q + CNT_W'(1);
                  end
               end
               if (mismatch && (werr_d >= LossThr)) begin
                  state_d  = StSeed;
                  fill_d   = 3'd0;
                  load_tap = 1'b1;
               end else if (win_q == WinLast) begin
                  win_d  = 8'd0;
                  werr_d = 8'd0;
               end
            end
            default: begin
               state_d  = StSeed;
               fill_d   = 3'd0;
               load_tap = 1'b1;
            end
         endcase
      end

      tap_d    = (load_tap || tap_init_q) ? tap : tap_q;
      locked_d = (state_d == StLocked);
   end

   // State registers; tap_init_q makes the first clock after reset sample the tap mask.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StSeed;
         shadow_q    <= 8'd0;
         fill_q      <= 3'd0;
         match_q     <= 8'd0;
         win_q       <= 8'd0;
         werr_q      <= 8'd0;
         tap_q       <= 8'd0;
         tap_init_q  <= 1'b1;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         win_q       <= win_d;
         werr_q      <= werr_d;
         tap_q       <= tap_d;
         tap_init_q  <= 1'b0;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Bench for lfsr_stream_checker: golden generator, behavioural reference model and a
// scoreboard queue; a second instance with a 2-bit counter exercises saturation.
module tb_lfsr_stream_checker;

   localparam int MsSeed   = 0;
   localparam int MsVerify = 1;
   localparam int MsLocked = 2;

   logic        clk;
   logic        reset;
   logic [7:0]  tap;
   logic        rx_valid;
   logic        rx_bit;
   logic        clear;
   logic        locked,   locked_s;
   logic        err_pulse, err_pulse_s;
   logic [15:0] err_count;
   logic [1:0]  err_count_s;

   lfsr_stream_checker u_dut (
      .clk       (clk),
      .reset     (reset),
      .tap       (tap),
      .rx_valid  (rx_valid),
      .rx_bit    (rx_bit),
      .clear     (clear),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count)
   );

   lfsr_stream_checker #(.CNT_W(2)) u_dut_sat (
      .clk       (clk),
      .reset     (reset),
      .tap       (tap),
      .rx_valid  (rx_valid),
      .rx_bit    (rx_bit),
      .clear     (clear),
      .locked    (locked_s),
      .err_pulse (err_pulse_s),
      .err_count (err_count_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic lck;
      logic pulse;
      int   cnt;
   } exp_t;

   exp_t sb_q[$];

   int n_assert = 0;
   int n_fail   = 0;

   // Golden transmitter and reference model state.
   logic [7:0] gen_state;
   int         m_state;
   logic [7:0] m_shadow;
   int         m_fill, m_match, m_win, m_werr, m_cnt;
   logic [7:0] m_tap;
   logic       m_pulse;

   task automatic chk(input string tag, input int obs, input int expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic gen_next(output logic b);
      logic fb;
      fb        = ^(gen_state & 8'hB8);
      gen_state = {gen_state[6:0], fb};
      b         = fb;
   endtask

   task automatic model_reset();
      m_state  = MsSeed;
      m_shadow = 8'd0;
      m_fill   = 0;
      m_match  = 0;
      m_win    = 0;
      m_werr   = 0;
      m_cnt    = 0;
      m_tap    = tap;
      m_pulse  = 1'b0;
   endtask

   task automatic enter_seed();
      m_state = MsSeed;
      m_fill  = 0;
      m_tap   = tap;
   endtask

   task automatic model_step(input logic v, input logic b, input logic c);
      logic pred;
      m_pulse = 1'b0;
      if (c) begin
         m_cnt = 0;
         enter_seed();
      end else if (v) begin
         pred = ^(m_shadow & m_tap);
         if (m_state == MsSeed) begin
            m_shadow = {m_shadow[6:0], b};
            m_fill++;
            if (m_fill == 8) begin
               m_state = MsVerify;
               m_match = 0;
            end
         end else if (m_state == MsVerify) begin
            m_shadow = {m_shadow[6:0], b};
            if (b == pred) begin
               m_match++;
               if (m_match == 16) begin
                  m_state = MsLocked;
                  m_win   = 0;
                  m_werr  = 0;
               end
            end else begin
               enter_seed();
            end
         end else begin
            m_shadow = {m_shadow[6:0], pred};
            if (b != pred) begin
               m_pulse = 1'b1;
               m_cnt++;
               m_werr++;
            end
            if (m_werr >= 4) begin
               enter_seed();
            end else begin
               m_win = (m_win + 1) % 32;
               if (m_win == 0) m_werr = 0;
            end
         end
      end
   endtask

   // One clock of stimulus; expectation is queued at drive time and checked after the edge.
   task automatic send(input logic v, input logic flip, input logic c);
      logic b;
      exp_t e;
      exp_t got;
      @(negedge clk);
      if (v) begin
         gen_next(b);
         b = b ^ flip;
      end else begin
         b = 1'($urandom_range(0, 1));
      end
      rx_valid = v;
      rx_bit   = b;
      clear    = c;
      model_step(v, b, c);
      e.lck   = (m_state == MsLocked);
      e.pulse = m_pulse;
      e.cnt   = m_cnt;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      chk("locked", int'(locked), int'(got.lck));
      chk("err_pulse", int'(err_pulse), int'(got.pulse));
      chk("err_count", int'(err_count), (got.cnt > 65535) ? 65535 : got.cnt);
      chk("locked_sat", int'(locked_s), int'(got.lck));
      chk("err_pulse_sat", int'(err_pulse_s), int'(got.pulse));
      chk("err_count_sat", int'(err_count_s), (got.cnt > 3) ? 3 : got.cnt);
      rx_valid = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic clean(input int n);
      for (int i = 0; i < n; i++) send(1'b1, 1'b0, 1'b0);
   endtask

   // Advance on clean bits to the start of a locked observation window (bounded).
   task automatic align();
      int guard;
      guard = 0;
      while ((m_state != MsLocked || m_win != 0) && guard < 100) begin
         send(1'b1, 1'b0, 1'b0);
         guard++;
      end
      chk("align_reached", guard < 100 ? 1 : 0, 1);
   endtask

   int pulses;
   int vc;
   logic v;

   initial begin
      reset     = 1'b1;
      tap       = 8'hB8;
      rx_valid  = 1'b0;
      rx_bit    = 1'b0;
      clear     = 1'b0;
      gen_state = 8'h01;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_locked", int'(locked), 0);
      chk("rst_err_pulse", int'(err_pulse), 0);
      chk("rst_err_count", int'(err_count), 0);
      @(negedge clk);
      reset = 1'b0;

      // 1: lock after exactly 24 valid bits, no errors on a clean stream
      for (int i = 1; i <= 1000; i++) begin
         send(1'b1, 1'b0, 1'b0);
         if (i == 23) chk("t1_not_locked_23", int'(locked), 0);
         if (i == 24) chk("t1_locked_24", int'(locked), 1);
      end
      chk("t1_err_count", int'(err_count), 0);

      // 2: single error, no multiplication
      send(1'b1, 1'b1, 1'b0);
      chk("t2_pulse", int'(err_pulse), 1);
      chk("t2_count", int'(err_count), 1);
      chk("t2_locked", int'(locked), 1);
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         send(1'b1, 1'b0, 1'b0);
         pulses += int'(err_pulse);
      end
      chk("t2_no_mult", pulses, 0);

      // tap changes while locked are ignored
      tap = 8'h00;
      clean(20);
      chk("tap_ignored_count", int'(err_count), 1);
      tap = 8'hB8;

      // 3: four errors in one window drop lock; relock after 24 clean bits
      send(1'b1, 1'b0, 1'b1);
      clean(24);
      chk("t3_relocked_after_clear", int'(locked), 1);
      align();
      for (int k = 0; k < 3; k++) begin
         send(1'b1, 1'b1, 1'b0);
         send(1'b1, 1'b0, 1'b0);
      end
      chk("t3_locked_before_4th", int'(locked), 1);
      send(1'b1, 1'b1, 1'b0);
      chk("t3_lost", int'(locked), 0);
      chk("t3_pulse", int'(err_pulse), 1);
      chk("t3_count", int'(err_count), 4);
      clean(23);
      chk("t3_not_yet", int'(locked), 0);
      clean(1);
      chk("t3_relock", int'(locked), 1);
      chk("t3_count_kept", int'(err_count), 4);

      // 4: three errors in each of two consecutive windows keep lock
      send(1'b1, 1'b0, 1'b1);
      clean(24);
      align();
      for (int w = 0; w < 2; w++) begin
         for (int k = 0; k < 3; k++) begin
            send(1'b1, 1'b1, 1'b0);
            clean(4);
         end
         align();
      end
      chk("t4_locked", int'(locked), 1);
      chk("t4_count", int'(err_count), 6);
      chk("t4_count_sat", int'(err_count_s), 3);

      // 6: five errors, then clear with a corrupted valid bit
      send(1'b1, 1'b0, 1'b1);
      clean(24);
      align();
      for (int k = 0; k < 3; k++) send(1'b1, 1'b1, 1'b0);
      align();
      for (int k = 0; k < 2; k++) send(1'b1, 1'b1, 1'b0);
      chk("t6_count5", int'(err_count), 5);
      chk("t6_sat3", int'(err_count_s), 3);
      send(1'b1, 1'b1, 1'b1);
      chk("t6_clr_pulse", int'(err_pulse), 0);
      chk("t6_clr_count", int'(err_count), 0);
      chk("t6_clr_locked", int'(locked), 0);

      // 5: corrupt bit 12 of acquisition; lock 24 bits after re-seed
      clean(11);
      send(1'b1, 1'b1, 1'b0);
      clean(12);
      chk("t5_no_lock_24", int'(locked), 0);
      clean(11);
      chk("t5_no_lock_35", int'(locked), 0);
      clean(1);
      chk("t5_lock_36", int'(locked), 1);

      // 5b: random rx_valid gaps keep bit-count latency
      send(1'b0, 1'b0, 1'b1);
      vc = 0;
      for (int guard = 0; guard < 500 && vc < 24; guard++) begin
         v = 1'($urandom_range(0, 1));
         send(v, 1'b0, 1'b0);
         if (v) begin
            vc++;
            if (vc == 23) chk("t5b_not_yet", int'(locked), 0);
         end
      end
      chk("t5b_bits", vc, 24);
      chk("t5b_locked", int'(locked), 1);

      // 6b: asynchronous reset while an error pulse is high
      send(1'b1, 1'b1, 1'b0);
      chk("t6b_pulse_pre", int'(err_pulse), 1);
      #2 reset = 1'b1;
      #1;
      chk("t6b_locked", int'(locked), 0);
      chk("t6b_pulse", int'(err_pulse), 0);
      chk("t6b_count", int'(err_count), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      clean(24);
      chk("t6b_relock", int'(locked), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
